maze_solver: RTL and testbench
==============================

Name: maze_solver

Overview:
- Consumes the 31-bit wall vector and bomb cell produced by the maze generator.
- Runs an iterative depth-first search from cell 0 to the target cell, one move per clock.
- Reports whether the target is reachable, the path length and a 20-bit mask of the cells on the path.
- The player-hint overlay and the auto-play logic use the path mask.

Parameters:
- COLS, 5, grid columns (fixed geometry; the wall map below assumes 5).
- ROWS, 4, grid rows.
- CELLS, 20, COLS*ROWS.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  level, sampled at clk; starts a solve when the block is idle.
- walls  in  31  1 = wall present. Bits 0..15 are the east wall of cell r*5+c (r=0..3, c=0..3), index r*4+c. Bits 16..30 are the south wall of cell r*5+c (r=0..2, c=0..4), index 16+r*5+c.
- target  in  5  goal cell, row-major (cell = row*5+col).
- busy  out  1  search in progress.
- done  out  1  one-cycle pulse when the result is valid.
- found  out  1  target reached.
- path_len  out  5  number of moves from cell 0 to the target.
- path_mask  out  20  bit i set when cell i lies on the path (cell 0 and the target included).

Behaviour:
- Reset (async, rst_n=0): state IDLE; busy, done, found, path_len, path_mask all 0; internal depth, visited, onpath and current cleared.
- States are IDLE and SEARCH only. done is a registered pulse and is never high for two consecutive cycles.
- IDLE:
  - On the edge where start=1: latch walls and target, set current=0, visited=0x00001, onpath=0x00001, depth=0, busy=1, go to SEARCH.
  - found, path_len and path_mask hold their last result until the next done.
- SEARCH: exactly one action per edge, first matching rule wins.
  1. target>=20: done=1, found=0, path_len=0, path_mask=0, busy=0, go to IDLE.
  2. current==target: done=1, found=1, path_len=depth, path_mask=onpath, busy=0, go to IDLE.
  3. An open, unvisited neighbour exists, checked in priority order E, S, W, N:
     - E exists if col<4 and walls[r*4+c]=0.
     - S exists if row<3 and walls[16+r*5+c]=0.
     - W exists if col>0 and walls[r*4+c-1]=0.
     - N exists if row>0 and walls[16+(r-1)*5+c]=0.
     - Action: push (stack[depth]=current, depth+1), current=neighbour, set visited and onpath bits of the neighbour.
  4. depth>0 (dead end): pop; clear the onpath bit of current, current=stack[depth-1], depth-1.
  5. Otherwise (exhausted at cell 0): done=1, found=0, path_len=0, path_mask=0, busy=0, go to IDLE.
- Stack: 20 x 5-bit entries. depth is 5 bits and never exceeds 19, because each cell is pushed at most once.
- Latency: done occurs at most 2*CELLS+1 edges after start is sampled.
- start while busy=1 is ignored. Changes to walls or target during SEARCH have no effect (latched copies are used).
- start held high: a new solve begins on the edge after done (state is IDLE there).
- rst_n low mid-search aborts immediately to the reset values; no done pulse is produced.

Test Plan:
- walls=0x0000_0000, target=19, start pulse:
  - 7 pushes, then the detect edge.
  - Required: done on edge 8 after start sampled, found=1, path_len=7, path_mask=0x8421F (cells 0,1,2,3,4,9,14,19), busy high for exactly 8 cycles.
- walls=0x7FFFFFFF, target=19 -> done on edge 1, found=0, path_len=0, path_mask=0x00000.
- Backtrack case: walls=0x7FFFFFFF with bits 0 and 16 cleared, target=5.
  - Sequence: push to 1, pop to 0, push to 5, detect.
  - Required: done on edge 4, found=1, path_len=1, path_mask=0x00021.
- Edge targets:
  - target=0 -> done on edge 1, found=1, path_len=0, path_mask=0x00001.
  - target=25 -> done on edge 1, found=0, path_mask=0.
- Busy-time disturbances on the walls=0 / target=19 run:
  - Toggle walls to 0x7FFFFFFF and pulse start mid-search -> result still found=1, path_len=7, path_mask=0x8421F, with only one done pulse.
- Reset mid-search: assert rst_n=0 on edge 3 of the walls=0 run.
  - Required: busy, done, found, path_len, path_mask all 0 asynchronously.
  - After release, a new start reproduces the full result.

Source files
------------

// File: rtl/maze_solver.sv
// Iterative depth-first maze solver for the fixed 5x4 grid, one move per clock.
// Reports reachability, path length and the mask of the cells on the found path.
module maze_solver #(
    parameter int COLS  = 5,
    parameter int ROWS  = 4,
    parameter int CELLS = 20
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [30:0] walls,
    input  logic [4:0]  target,
    output logic        busy,
    output logic        done,
    output logic        found,
    output logic [4:0]  path_len,
    output logic [19:0] path_mask
);
    localparam logic [4:0] NCOLS    = 5'(COLS);
    localparam logic [4:0] LAST_COL = 5'(COLS - 1);
    localparam logic [4:0] LAST_ROW = 5'(ROWS - 1);
    localparam logic [4:0] NCELLS   = 5'(CELLS);

    typedef enum logic {IDLE, SEARCH} state_t;

    state_t           state;
    logic [30:0]      walls_q;
    logic [4:0]       target_q;
    logic [4:0]       current;
    logic [4:0]       depth;
    logic [CELLS-1:0] visited;
    logic [CELLS-1:0] onpath;
    logic [4:0]       stack [CELLS];

    logic [4:0] row, col, e_idx, s_idx, nxt;
    logic       e_ok, s_ok, w_ok, n_ok, adv, push;

    assign row   = current / NCOLS;
    assign col   = current - row * NCOLS;
    assign e_idx = (row << 2) + col;
    assign s_idx = 5'd16 + row * NCOLS + col;

    // Out-of-range indices only occur when the geometry guard is already false.
    assign e_ok = (col < LAST_COL) && !walls_q[e_idx]         && !visited[current + 5'd1];
    assign s_ok = (row < LAST_ROW) && !walls_q[s_idx]         && !visited[current + NCOLS];
    assign w_ok = (col != 5'd0)    && !walls_q[e_idx - 5'd1]  && !visited[current - 5'd1];
    assign n_ok = (row != 5'd0)    && !walls_q[s_idx - NCOLS] && !visited[current - NCOLS];
    assign adv  = e_ok || s_ok || w_ok || n_ok;

    always_comb begin
        nxt = current;
        if (e_ok)      nxt = current + 5'd1;
        else if (s_ok) nxt = current + NCOLS;
        else if (w_ok) nxt = current - 5'd1;
        else if (n_ok) nxt = current - NCOLS;
    end

    assign push = (state == SEARCH) && (target_q < NCELLS) && (current != target_q) && adv;

    // Stack contents are only read below depth, so they need no reset.
    always_ff @(posedge clk) begin
        if (push) stack[depth] <= current;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            walls_q   <= '0;
            target_q  <= '0;
            current   <= '0;
            depth     <= '0;
            visited   <= '0;
            onpath    <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            found     <= 1'b0;
            path_len  <= '0;
            path_mask <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        walls_q  <= walls;
                        target_q <= target;
                        current  <= '0;
                        visited  <= CELLS'(1);
                        onpath   <= CELLS'(1);
                        depth    <= '0;
                        busy     <= 1'b1;
                        state    <= SEARCH;
                    end
                end
                SEARCH: begin
                    if (target_q >= NCELLS) begin
                        done      <= 1'b1;
                        found     <= 1'b0;
                        path_len  <= '0;
                        path_mask <= '0;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end else if (current == target_q) begin
                        done      <= 1'b1;
                        found     <= 1'b1;
                        path_len  <= depth;
                        path_mask <= onpath;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end else if (adv) begin
                        depth        <= depth + 5'd1;
                        current      <= nxt;
                        visited[nxt] <= 1'b1;
                        onpath[nxt]  <= 1'b1;
                    end else if (depth != 5'd0) begin
                        onpath[current] <= 1'b0;
                        current         <= stack[depth - 5'd1];
                        depth           <= depth - 5'd1;
                    end else begin
                        done      <= 1'b1;
                        found     <= 1'b0;
                        path_len  <= '0;
                        path_mask <= '0;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_maze_solver.sv
// Bench for maze_solver: directed cases plus random mazes checked against a
// queue-based depth-first search model that also predicts the done edge.
module tb_maze_solver;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [30:0] walls = '0;
    logic [4:0]  target = '0;
    logic        busy, done, found;
    logic [4:0]  path_len;
    logic [19:0] path_mask;

    int n_checks = 0;
    int n_errors = 0;

    maze_solver dut (
        .clk(clk), .rst_n(rst_n), .start(start), .walls(walls), .target(target),
        .busy(busy), .done(done), .found(found), .path_len(path_len), .path_mask(path_mask)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Next open, unvisited neighbour in E,S,W,N order, or -1.
    function automatic int next_open(input logic [30:0] w, input int cur, input bit vis[20]);
        int r, c;
        r = cur / 5;
        c = cur % 5;
        if (c < 4 && !w[r*4+c]        && !vis[cur+1]) return cur + 1;
        if (r < 3 && !w[16+r*5+c]     && !vis[cur+5]) return cur + 5;
        if (c > 0 && !w[r*4+c-1]      && !vis[cur-1]) return cur - 1;
        if (r > 0 && !w[16+(r-1)*5+c] && !vis[cur-5]) return cur - 5;
        return -1;
    endfunction

    // edges = number of clock edges after start is sampled until done.
    task automatic ref_solve(input logic [30:0] w, input int tgt,
                             output int f, output int len, output int mask, output int edges);
        int  path[$];
        bit  vis[20];
        int  cur, nb;
        f = 0; len = 0; mask = 0; edges = 1;
        if (tgt >= 20) return;
        foreach (vis[i]) vis[i] = 1'b0;
        path.push_back(0);
        vis[0] = 1'b1;
        edges = 0;
        for (int step = 0; step < 200; step++) begin
            edges++;
            cur = path[$];
            if (cur == tgt) begin
                f = 1;
                len = path.size() - 1;
                foreach (path[i]) mask |= (1 << path[i]);
                return;
            end
            nb = next_open(w, cur, vis);
            if (nb >= 0) begin
                vis[nb] = 1'b1;
                path.push_back(nb);
            end else if (path.size() > 1) begin
                void'(path.pop_back());
            end else begin
                return;
            end
        end
    endtask

    // Runs one solve; optional disturbance toggles walls and re-pulses start mid-search.
    task automatic do_solve(input string tag, input logic [30:0] w, input int tgt, input bit disturb);
        int ef, elen, emask, eedges;
        int done_edge, busy_cnt, done_cnt;
        ref_solve(w, tgt, ef, elen, emask, eedges);
        @(negedge clk);
        walls = w;
        target = 5'(tgt);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        done_edge = -1;
        busy_cnt = 0;
        done_cnt = 0;
        for (int k = 1; k <= 60; k++) begin
            if (busy) busy_cnt++;
            @(negedge clk);
            if (disturb && k == 3) begin
                walls = 31'h7FFF_FFFF;
                start = 1'b1;
            end
            if (disturb && k == 4) start = 1'b0;
            if (done) begin
                done_cnt++;
                done_edge = k;
                break;
            end
        end
        start = 1'b0;
        check({tag, ":done_edge"}, done_edge, eedges);
        check({tag, ":found"}, int'(found), ef);
        check({tag, ":path_len"}, int'(path_len), elen);
        check({tag, ":path_mask"}, int'(path_mask), emask);
        check({tag, ":busy_cycles"}, busy_cnt, eedges);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (done) done_cnt++;
        end
        check({tag, ":done_pulses"}, done_cnt, 1);
    endtask

    initial begin
        logic [30:0] w;
        int          t;

        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check("reset:busy", int'(busy), 0);
        check("reset:done", int'(done), 0);
        check("reset:found", int'(found), 0);
        check("reset:path_len", int'(path_len), 0);
        check("reset:path_mask", int'(path_mask), 0);
        rst_n = 1'b1;

        do_solve("open_19", 31'h0, 19, 1'b0);
        check("open_19:const_mask", int'(path_mask), 32'h8421F);
        do_solve("closed_19", 31'h7FFF_FFFF, 19, 1'b0);
        do_solve("backtrack_5", 31'h7FFE_FFFE, 5, 1'b0);
        check("backtrack_5:const_mask", int'(path_mask), 32'h00021);
        do_solve("target_0", 31'h0, 0, 1'b0);
        do_solve("target_25", 31'h0, 25, 1'b0);
        do_solve("disturbed", 31'h0, 19, 1'b1);
        check("disturbed:const_len", int'(path_len), 7);

        // Reset three edges into a solve, after a found result is on the outputs.
        @(negedge clk);
        walls = 31'h0;
        target = 5'd19;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midreset:busy", int'(busy), 0);
        check("midreset:found", int'(found), 0);
        check("midreset:path_len", int'(path_len), 0);
        check("midreset:path_mask", int'(path_mask), 0);
        check("midreset:done", int'(done), 0);
        @(negedge clk);
        rst_n = 1'b1;
        do_solve("after_reset", 31'h0, 19, 1'b0);

        for (int n = 0; n < 25; n++) begin
            w = '0;
            for (int b = 0; b < 31; b++) w[b] = ($urandom_range(0, 2) == 0);
            t = $urandom_range(0, 23);
            do_solve($sformatf("rand%0d", n), w, t, 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
